// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv output-side blocks.
package conv_pkg;

  localparam int PIX_W  = 8;
  localparam int CONV_W = 16;

  // One FIFO entry: markers above the pixel byte.
  typedef struct packed {
    logic             eof;
    logic             eol;
    logic             sof;
    logic [PIX_W-1:0] data;
  } sink_entry_t;

  typedef enum logic {
    SINK_IDLE,
    SINK_ACTIVE
  } sink_state_t;

  // Clamp a non-negative 15-bit value into an 8-bit pixel.
  function automatic logic [PIX_W-1:0] sat_u8(input logic [CONV_W-2:0] s);
    return (s > (CONV_W-1)'(255)) ? {PIX_W{1'b1}} : s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_result_sink_if.sv
// Pixel stream toward the frame writer: valid/ready plus frame markers.
interface conv_result_sink_if;
  import conv_pkg::*;

  logic [PIX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;

  modport master (
    output out_data, out_valid, out_sof, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sof, out_eol, out_eof,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO; head is visible on rdata while not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // The extra top pointer bit separates the full and empty cases when indices match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  // Pointer update; clear empties the FIFO regardless of traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/conv_result_sink.sv
// Consumes the raw conv output stream, drops border columns, post-processes
// to 8-bit pixels and queues them with frame markers for the frame writer.
module conv_result_sink
  import conv_pkg::*;
#(
  parameter int LINE_W     = 480,
  parameter int LINES      = 478,
  parameter int DROP_COLS  = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [CONV_W-1:0]  data_in,
  input  logic               data_in_en,
  input  logic               relu_en,
  input  logic [3:0]         shift,
  conv_result_sink_if.master out_if,
  output logic               overflow,
  output logic               neg_seen,
  output logic               frame_done
);
  localparam int COL_W   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int ROW_W   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = $bits(sink_entry_t);

  sink_state_t       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, col_cur;
  logic [ROW_W-1:0]  row_q, row_d, row_cur;
  logic              last_col, last_row, keep, mark_sof, mark_eof;
  logic [CONV_W-2:0] relu_val, shifted;
  sink_entry_t       entry_new;
  logic              stage_valid_q;
  sink_entry_t       stage_entry_q;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0] fifo_rdata;
  sink_entry_t       fifo_head;
  logic              overflow_q, neg_seen_q, frame_done_q;

  // While idle the position is frame start, so the first sample is col 0, row 0.
  assign col_cur  = (state_q == SINK_IDLE) ? '0 : col_q;
  assign row_cur  = (state_q == SINK_IDLE) ? '0 : row_q;
  assign last_col = (col_cur == COL_W'(LINE_W - 1));
  assign last_row = (row_cur == ROW_W'(LINES - 1));
  assign keep     = (col_cur >= COL_W'(DROP_COLS));
  assign mark_sof = (row_cur == '0) && (col_cur == COL_W'(DROP_COLS));
  assign mark_eof = last_col && last_row;

  // Negative samples clip to zero whatever relu_en says; relu_en only affects neg_seen.
  assign relu_val  = data_in[CONV_W-1] ? '0 : data_in[CONV_W-2:0];
  assign shifted   = relu_val >> shift;
  assign entry_new = '{eof: mark_eof, eol: last_col, sof: mark_sof, data: sat_u8(shifted)};

  // Position counters and FSM next state; counters advance only on accepted samples.
  always_comb begin
    state_d = state_q;
    col_d   = col_cur;
    row_d   = row_cur;
    if (data_in_en) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
      state_d = mark_eof ? SINK_IDLE : SINK_ACTIVE;
    end
  end

  // State and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SINK_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else if (clr) begin
      state_q <= SINK_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Registered post-process stage feeding the FIFO write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_entry_q <= '0;
    end else if (clr) begin
      stage_valid_q <= 1'b0;
      stage_entry_q <= '0;
    end else begin
      stage_valid_q <= data_in_en && keep;
      if (data_in_en && keep) stage_entry_q <= entry_new;
    end
  end

  assign fifo_push = stage_valid_q;
  assign fifo_pop  = !fifo_empty && out_if.out_ready;

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (fifo_push),
    .wdata (stage_entry_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fifo_head = fifo_rdata;

  // Sticky status and EOF pulse; clear takes priority over any set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q   <= 1'b0;
      neg_seen_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (clr) begin
      overflow_q   <= 1'b0;
      neg_seen_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (fifo_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      if (data_in_en && data_in[CONV_W-1] && !relu_en) neg_seen_q <= 1'b1;
      frame_done_q <= fifo_pop && fifo_head.eof;
    end
  end

  // Occupancy can never exceed the configured depth.
  assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CNT_W'(FIFO_DEPTH));

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : fifo_head.data;
  assign out_if.out_sof   = !fifo_empty && fifo_head.sof;
  assign out_if.out_eol   = !fifo_empty && fifo_head.eol;
  assign out_if.out_eof   = !fifo_empty && fifo_head.eof;
  assign overflow         = overflow_q;
  assign neg_seen         = neg_seen_q;
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_conv_result_sink.sv
// Scoreboard bench for conv_result_sink on a small 8x3 frame geometry.
module tb_conv_result_sink;
  import conv_pkg::*;

  localparam int LINE_W = 8;
  localparam int LINES  = 3;
  localparam int DROP   = 2;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] dataIn = '0;
  logic        dataInEn = 1'b0;
  logic        reluEn = 1'b1;
  logic [3:0]  shift = '0;
  logic        overflow, negSeen, frameDone;

  conv_result_sink_if sinkIf ();

  conv_result_sink #(
    .LINE_W     (LINE_W),
    .LINES      (LINES),
    .DROP_COLS  (DROP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .data_in    (dataIn),
    .data_in_en (dataInEn),
    .relu_en    (reluEn),
    .shift      (shift),
    .out_if     (sinkIf.master),
    .overflow   (overflow),
    .neg_seen   (negSeen),
    .frame_done (frameDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frameDoneCount = 0;
  int bCol = 0;
  int bRow = 0;
  sink_entry_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Drive one sample for one clock; record the expected pixel when it is kept.
  task automatic applyStimulus(input logic [15:0] x, input logic [7:0] expData, input bit record);
    sink_entry_t e;
    if (bCol >= DROP && record) begin
      e.sof  = (bRow == 0) && (bCol == DROP);
      e.eol  = (bCol == LINE_W - 1);
      e.eof  = e.eol && (bRow == LINES - 1);
      e.data = expData;
      expQ.push_back(e);
    end
    dataIn   = x;
    dataInEn = 1'b1;
    @(posedge clk); #1;
    dataInEn = 1'b0;
    if (bCol == LINE_W - 1) begin
      bCol = 0;
      bRow = (bRow == LINES - 1) ? 0 : bRow + 1;
    end else begin
      bCol++;
    end
  endtask

  task automatic sendRamp();
    for (int i = 0; i < LINE_W * LINES; i++) applyStimulus(16'(i), 8'(i), 1'b1);
  endtask

  task automatic waitDrain(input string name);
    for (int c = 0; c < 300 && expQ.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput(name, 32'(expQ.size()), 0);
    checkOutput({name, "Idle"}, 32'(sinkIf.out_valid), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Valid"}, 32'(sinkIf.out_valid), 0);
    checkOutput({tag, "Data"}, 32'(sinkIf.out_data), 0);
    checkOutput({tag, "Sof"}, 32'(sinkIf.out_sof), 0);
    checkOutput({tag, "Eol"}, 32'(sinkIf.out_eol), 0);
    checkOutput({tag, "Eof"}, 32'(sinkIf.out_eof), 0);
    checkOutput({tag, "Ovf"}, 32'(overflow), 0);
    checkOutput({tag, "Neg"}, 32'(negSeen), 0);
    checkOutput({tag, "Done"}, 32'(frameDone), 0);
  endtask

  // Monitor: compare every handshaken beat against the scoreboard head.
  always @(negedge clk) begin : monitor
    sink_entry_t e;
    if (rst_n && frameDone) frameDoneCount++;
    if (rst_n && sinkIf.out_valid && sinkIf.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPixel actual %0d required none", sinkIf.out_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("pixData", 32'(sinkIf.out_data), 32'(e.data));
        checkOutput("pixSof", 32'(sinkIf.out_sof), 32'(e.sof));
        checkOutput("pixEol", 32'(sinkIf.out_eol), 32'(e.eol));
        checkOutput("pixEof", 32'(sinkIf.out_eof), 32'(e.eof));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int kept;
    bit rec;
    sinkIf.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: ramp frame, full throughput
    $display("[TB] ramp frame");
    for (int i = 0; i < LINE_W * LINES; i++) begin
      applyStimulus(16'(i), 8'(i), 1'b1);
      if (i == 2) checkOutput("latencyStage", 32'(sinkIf.out_valid), 0);
      if (i == 3) begin
        checkOutput("latencyValid", 32'(sinkIf.out_valid), 1);
        checkOutput("latencyData", 32'(sinkIf.out_data), 2);
      end
    end
    waitDrain("rampDrain");
    checkOutput("rampFrameDone", 32'(frameDoneCount), 1);
    checkOutput("rampOverflow", 32'(overflow), 0);
    checkOutput("rampNegSeen", 32'(negSeen), 0);

    // Scenario 2: arithmetic with shift 2
    $display("[TB] arithmetic");
    shift = 4'd2;
    applyStimulus(16'd0, 8'd0, 1'b1);
    applyStimulus(16'd0, 8'd0, 1'b1);
    applyStimulus(16'hFFF9, 8'd0, 1'b1);
    checkOutput("negReluOn", 32'(negSeen), 0);
    reluEn = 1'b0;
    applyStimulus(16'hFFFB, 8'd0, 1'b1);
    checkOutput("negReluOff", 32'(negSeen), 1);
    reluEn = 1'b1;
    applyStimulus(16'd1023, 8'd255, 1'b1);
    applyStimulus(16'd1020, 8'd255, 1'b1);
    applyStimulus(16'd800, 8'd200, 1'b1);
    applyStimulus(16'd32767, 8'd255, 1'b1);
    while (bCol != 0 || bRow != 0) applyStimulus(16'd0, 8'd0, 1'b1);
    waitDrain("arithDrain");
    checkOutput("arithFrameDone", 32'(frameDoneCount), 2);
    shift = 4'd0;

    // Scenario 3: backpressure with 20 kept pixels, 16 retained
    $display("[TB] backpressure");
    sinkIf.out_ready = 1'b0;
    kept = 0;
    for (int i = 0; i < LINE_W * LINES + 4; i++) begin
      rec = 1'b0;
      if (bCol >= DROP) begin
        rec = (kept < DEPTH);
        kept++;
      end
      applyStimulus(16'(i % (LINE_W * LINES)), 8'(i % (LINE_W * LINES)), rec);
    end
    @(posedge clk); #1;
    checkOutput("bpOverflow", 32'(overflow), 1);
    checkOutput("bpHoldValid", 32'(sinkIf.out_valid), 1);
    checkOutput("bpHoldData", 32'(sinkIf.out_data), 2);
    checkOutput("bpHoldSof", 32'(sinkIf.out_sof), 1);
    sinkIf.out_ready = 1'b1;
    for (int i = 4; i < LINE_W * LINES; i++) applyStimulus(16'(i), 8'(i), 1'b1);
    waitDrain("bpDrain");
    checkOutput("bpFrameDone", 32'(frameDoneCount), 3);
    sendRamp();
    waitDrain("bpNextFrame");
    checkOutput("bpNextFrameDone", 32'(frameDoneCount), 4);

    // Scenario 5: clear mid-line, clear beats a simultaneous neg_seen set
    $display("[TB] clear");
    sinkIf.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(16'(i), 8'(i), 1'b1);
    checkOutput("clrPreValid", 32'(sinkIf.out_valid), 1);
    clr      = 1'b1;
    reluEn   = 1'b0;
    dataIn   = 16'hFFFB;
    dataInEn = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    dataInEn = 1'b0;
    reluEn   = 1'b1;
    checkOutput("clrValid", 32'(sinkIf.out_valid), 0);
    checkOutput("clrOverflow", 32'(overflow), 0);
    checkOutput("clrNegSeen", 32'(negSeen), 0);
    expQ.delete();
    bCol = 0;
    bRow = 0;
    sinkIf.out_ready = 1'b1;
    sendRamp();
    waitDrain("clrResume");
    checkOutput("clrFrameDone", 32'(frameDoneCount), 5);

    // Scenario 4: FIFO full with a simultaneous pop and push
    $display("[TB] full plus pop");
    sinkIf.out_ready = 1'b0;
    for (int i = 0; i < LINE_W * LINES - 1; i++) applyStimulus(16'(i), 8'(i), 1'b1);
    sinkIf.out_ready = 1'b1;
    applyStimulus(16'(LINE_W * LINES - 1), 8'(LINE_W * LINES - 1), 1'b1);
    waitDrain("fullPopDrain");
    checkOutput("fullPopOverflow", 32'(overflow), 0);
    checkOutput("fullPopFrameDone", 32'(frameDoneCount), 6);

    // Scenario 6: asynchronous reset mid-frame
    $display("[TB] async reset");
    sinkIf.out_ready = 1'b0;
    reluEn = 1'b0;
    applyStimulus(16'hFFFB, 8'd0, 1'b1);
    reluEn = 1'b1;
    for (int i = 1; i < 10; i++) applyStimulus(16'(i), 8'(i), 1'b1);
    checkOutput("rstPreNeg", 32'(negSeen), 1);
    checkOutput("rstPreValid", 32'(sinkIf.out_valid), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncRst");
    expQ.delete();
    bCol = 0;
    bRow = 0;
    @(posedge clk); #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sinkIf.out_ready = 1'b1;
    sendRamp();
    waitDrain("rstResume");
    checkOutput("rstFrameDone", 32'(frameDoneCount), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_sink.md
# conv_result_sink

Output-side companion of `conv`. It consumes the raw `data_out`/`data_out_en` stream and tracks line and frame position. It drops the border columns that are not yet valid, then applies ReLU, a programmable shift and saturation to 8-bit pixels. Results are buffered in a small FIFO behind a valid/ready handshake toward the downstream frame writer, with SOF/EOL/EOF markers.

## Interface
- `LINE_W`, 480: conv output samples per line, border columns included.
- `LINES`, 478: conv output lines per frame.
- `DROP_COLS`, 2: leading columns discarded on every line.
- `FIFO_DEPTH`, 16: output FIFO entries; must be a power of two, at least 4.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of counters, FSM, FIFO and `overflow`.
- `data_in` in 16: conv result, two's-complement signed.
- `data_in_en` in 1: `data_in` valid this cycle. There is no backpressure toward `conv`.
- `relu_en` in 1: when 1, negative samples become 0. When 0, negative samples saturate to 0 via the clip stage; behaviour is identical except the `neg_seen` flag.
- `shift` in 4: arithmetic right shift applied before saturation.
- `out_data` out 8: pixel.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head.
- `out_sof` out 1: head is the first kept pixel of the frame.
- `out_eol` out 1: head is the last pixel of a line.
- `out_eof` out 1: head is the last pixel of the frame.
- `overflow` out 1: sticky; a kept pixel was lost because the FIFO was full.
- `neg_seen` out 1: sticky; a negative sample arrived while `relu_en`=0.
- `frame_done` out 1: one-cycle pulse when the EOF beat handshakes.

## Operation
- Counters:
  - `col` runs 0..LINE_W-1 and `row` runs 0..LINES-1.
  - Both advance only on `data_in_en`.
  - `col` wraps to 0 and increments `row` at LINE_W-1.
  - `row` wraps to 0 after the last column of line LINES-1.
- Kept pixel: a sample with `col` >= DROP_COLS. Other samples are discarded silently.
- Marker flags:
  - SOF = (`row`==0 and `col`==DROP_COLS).
  - EOL = (`col`==LINE_W-1).
  - EOF = EOL and (`row`==LINES-1).
- Arithmetic, for a signed 16-bit value x:
  - v = (x<0) ? 0 : x, applied regardless of `relu_en`.
  - s = v >> `shift`, a 15-bit unsigned result.
  - `out_data` = (s>255) ? 255 : s[7:0].
  - `neg_seen` is set when x<0 and `relu_en`=0.
- FSM, two states:
  - IDLE: counters at 0. The first `data_in_en` moves to ACTIVE and is counted as `col` 0, `row` 0.
  - ACTIVE: the sample that produces EOF returns the FSM to IDLE.
  - `clr` forces IDLE from either state.
- FIFO: first-word fall-through, entries {eof, eol, sof, data[7:0]}.
  - A push is accepted when not full, or when a pop happens in the same cycle.
  - A push refused while full drops that pixel and sets `overflow`. The counters still advance, so frame geometry is preserved.
  - A pop occurs when `out_valid` && `out_ready`.
- Output rules:
  - `out_data` and the marker outputs hold their value while `out_valid`=1 and `out_ready`=0.
  - They are don't-care when `out_valid`=0; the RTL drives 0.

## Timing
- Reset values: `out_valid`, `out_sof`, `out_eol`, `out_eof`, `overflow`, `neg_seen` and `frame_done` are 0. `out_data`=0, FSM=IDLE, counters=0, FIFO empty.
- Pipeline: one registered post-process stage followed by the FIFO write.
  - A sample accepted at edge N is written at edge N+1.
  - With the FIFO empty, `out_valid` rises after edge N+1.
  - Latency is 2 cycles from `data_in_en` to `out_valid`.
- Full throughput: one pixel per cycle in and out when `out_ready`=1.
- `frame_done` is high for the cycle after the EOF pop edge.
- `clr` takes effect at the next edge:
  - The pipeline stage and FIFO empty and counters go to 0.
  - Stickies clear, and `clr` wins over a simultaneous push or set.
- Asynchronous reset in mid-frame discards all state. The next `data_in_en` is taken as the start of a frame.

## Structure
- Shared package `conv_pkg`:
  - `PIX_W`=8 and `CONV_W`=16.
  - The FIFO entry struct `sink_entry_t` {eof, eol, sof, data}.
  - A `sat_u8` function, reused by future output blocks.
- Sub-module `sync_fifo_fwft`, parameterised on width and depth:
  - Provides count, full and empty.
  - Pointers wrap modulo FIFO_DEPTH, with an extra pointer bit to distinguish full from empty.
- The top level holds the counters, FSM, post-process stage and sticky flags.

## Test plan
- LINE_W=8, LINES=3, DROP_COLS=2, `out_ready`=1, ramp input 0..23 with `shift`=0:
  - 18 pixels out, values 2..7, 10..15, 18..23.
  - SOF on value 2, EOL on 7/15/23, EOF on 23.
  - `frame_done` pulses once, and the first `out_valid` comes 2 cycles after the first kept sample.
- Arithmetic, `shift`=2:
  - Input -5 gives 0, and sets `neg_seen` when `relu_en`=0.
  - Input 1023 gives 255, input 1020 gives 255, input 800 gives 200.
  - Input 32767 gives 255.
- Backpressure: hold `out_ready`=0 for 20 continuous kept pixels with FIFO_DEPTH=16.
  - Exactly 16 are retained and `overflow` becomes 1.
  - Releasing `out_ready` drains 16 pixels in order with markers intact.
  - The next frame's SOF lands on the correct pixel.
- Full plus simultaneous pop: with the FIFO full, `out_ready`=1 and one push in the same cycle.
  - The push is accepted and `overflow` stays 0.
- Assert `clr` mid-line, then resume with a new frame.
  - `out_valid` is 0 the cycle after the clear edge and the stickies are 0.
  - The first kept output carries SOF.
- Drop `rst_n` asynchronously between clock edges mid-frame.
  - All outputs go to 0 immediately.
  - After release, a full frame is reproduced exactly as in scenario 1.
